// File: rtl/larson_scan_monitor.sv
// Passive monitor for the 16-line active-low scanner selection bus.
// Optional sweep counter/pulse: define LARSON_MONITOR_SWEEP_COUNT_EN.
module larson_scan_monitor #(
  parameter int LOCK_COUNT = 4,
  parameter int SWEEP_W    = 8
) (
  input  logic               i_clk,
  input  logic               i_n_rst,
  input  logic [15:0]        i_selection,
  input  logic               i_sample,
  input  logic               i_clear,
  output logic [3:0]         o_position,
  output logic               o_valid,
  output logic               o_direction,
  output logic               o_locked,
  output logic               o_fault,
  output logic [1:0]         o_fault_code,
  output logic [SWEEP_W-1:0] o_sweep_count,
  output logic               o_sweep_pulse
);

  typedef enum logic [2:0] {
    IDLE, SEED, UP, DOWN, FAULT
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  pos_q, pos_d;
  logic        valid_q, valid_d;
  logic        dir_q, dir_d;
  logic [3:0]  lock_q, lock_d;
  logic [1:0]  code_q, code_d;

  logic [15:0] sel_low;
  logic        legal;
  logic [3:0]  p;
  logic [4:0]  delta;
  logic        hold, step_up, step_dn;
  logic [3:0]  lock_inc;

  always_comb begin
    sel_low = ~i_selection;
    legal   = (sel_low != 16'd0) &&
              ((sel_low & (sel_low - 16'd1)) == 16'd0);
    p = 4'd0;
    for (int i = 0; i < 16; i++)
      if (sel_low[i]) p = 4'(i);
    delta   = {1'b0, p} - {1'b0, pos_q};
    hold    = legal && (delta == 5'd0);
    step_up = legal && (delta == 5'd1);
    step_dn = legal && (delta == 5'h1f);
    lock_inc = (lock_q == 4'hf) ? lock_q : lock_q + 4'd1;
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      state_q <= IDLE;
      pos_q   <= 4'd0;
      valid_q <= 1'b0;
      dir_q   <= 1'b0;
      lock_q  <= 4'd0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      valid_q <= valid_d;
      dir_q   <= dir_d;
      lock_q  <= lock_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    valid_d = valid_q;
    dir_d   = dir_q;
    lock_d  = lock_q;
    code_d  = code_q;
    if (i_clear) begin
      state_d = IDLE;
      valid_d = 1'b0;
      lock_d  = 4'd0;
      code_d  = 2'b00;
    end else if (i_sample) begin
      unique case (state_q)
        IDLE: if (legal) begin
          pos_d   = p;
          valid_d = 1'b1;
          state_d = SEED;
        end
        SEED: begin
          if (!legal) begin
            state_d = IDLE;
            valid_d = 1'b0;
            lock_d  = 4'd0;
          end else if (step_up) begin
            pos_d   = p;
            state_d = UP;
            dir_d   = 1'b1;
            lock_d  = lock_inc;
          end else if (step_dn) begin
            pos_d   = p;
            state_d = DOWN;
            dir_d   = 1'b0;
            lock_d  = lock_inc;
          end else if (!hold) begin
            pos_d = p;
          end
        end
        UP, DOWN: begin
          // forward step for the current direction
          if ((state_q == UP && step_up) ||
              (state_q == DOWN && step_dn)) begin
            pos_d  = p;
            lock_d = lock_inc;
            if (state_q == UP && p == 4'd15) begin
              state_d = DOWN;
              dir_d   = 1'b0;
            end else if (state_q == DOWN && p == 4'd0) begin
              state_d = UP;
              dir_d   = 1'b1;
            end
          end else if (!hold) begin
            state_d = FAULT;
            lock_d  = 4'd0;
            if (!legal)
              code_d = 2'b01;
            else if (step_up || step_dn)
              code_d = 2'b11;
            else
              code_d = 2'b10;
          end
        end
        FAULT: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    o_position   = pos_q;
    o_valid      = valid_q;
    o_direction  = dir_q;
    o_fault      = (state_q == FAULT);
    o_fault_code = code_q;
    o_locked     = ((state_q == UP) || (state_q == DOWN)) &&
                   (lock_q >= 4'(LOCK_COUNT));
  end

`ifdef LARSON_MONITOR_SWEEP_COUNT_EN
  logic               sweep_hit;
  logic [SWEEP_W-1:0] sweep_q;
  logic               pulse_q;

  assign sweep_hit = i_sample && !i_clear &&
    ((state_q == UP && step_up && p == 4'd15) ||
     (state_q == DOWN && step_dn && p == 4'd0));

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      sweep_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= sweep_hit;
      if (sweep_hit) sweep_q <= sweep_q + 1'b1;
    end
  end

  assign o_sweep_count = sweep_q;
  assign o_sweep_pulse = pulse_q;
`else
  assign o_sweep_count = '0;
  assign o_sweep_pulse = 1'b0;
`endif

endmodule

// File: doc/larson_scan_monitor.md
# larson_scan_monitor

Passive observer for the 16-line scanner selection bus: samples the active-low one-hot lines driven by the 74x154 decoder, re-encodes them to a 4-bit position, and tracks the bounce pattern 0→15→0. It checks that pattern, flags protocol violations, and counts completed sweeps. It sits on the receiving end of the scanner's selection bus, either in the test harness or in a companion board controller, and never drives the bus.

## Interface

Parameters:
- `LOCK_COUNT`, default 4: number of consecutive legal steps before `o_locked` asserts (1..15).
- `SWEEP_W`, default 8: width of the sweep counter.

Ports:
- `i_clk` in 1: system clock.
- `i_n_rst` in 1: reset, asynchronous assert, active-low.
- `i_selection` in 16: scanner selection lines, active-low one-hot; bit n low means position n.
- `i_sample` in 1: sample strobe, synchronous to `i_clk`, one cycle per scanner step.
- `i_clear` in 1: synchronous clear of fault and tracking; returns to IDLE.
- `o_position` out 4: last legally decoded position.
- `o_valid` out 1: `o_position` holds a decoded value.
- `o_direction` out 1: 1 = ascending, 0 = descending; meaningful in UP/DOWN only.
- `o_locked` out 1: tracking confirmed.
- `o_fault` out 1: sticky fault flag.
- `o_fault_code` out 2: 00 none, 01 not one-hot, 10 jump (|Δ|>1), 11 mid-sweep reversal.
- `o_sweep_count` out SWEEP_W: completed sweeps, wraps modulo 2^SWEEP_W.
- `o_sweep_pulse` out 1: one-cycle pulse per completed sweep.

## Operation

- Legal sample: exactly one bit of `i_selection` is 0. Decoded position p = index of that bit. Δ = p − `o_position`, taken as a signed 5-bit value.
- Inputs are evaluated only in cycles where `i_sample`=1. All other cycles hold every output, except `o_sweep_pulse`, which returns to 0.
- If Δ = 0 on a legal sample (oversampling hold), no state change, no lock progress, no fault.
- State machine states are IDLE, SEED, UP, DOWN and FAULT.
  - IDLE: a legal sample stores p, sets `o_valid`=1, and moves to SEED. An illegal sample is ignored.
  - SEED: legal p with Δ=+1 → UP. Legal p with Δ=−1 → DOWN. Any other legal p reseeds (store p, stay in SEED). An illegal sample → IDLE with `o_valid`=0. No faults are raised in IDLE or SEED.
  - UP: legal p with Δ=+1 stores p. Reaching 15 counts one sweep and moves to DOWN. A legal Δ=−1 is code 11. A legal |Δ|>1 is code 10. An illegal sample is code 01.
  - DOWN: mirror of UP. Reaching 0 counts one sweep and moves to UP.
  - FAULT: `o_fault`=1 and `o_fault_code` latched. `o_position`, `o_direction` and the counters are frozen. `o_locked`=0. Samples are ignored. Exit only via `i_clear` or reset.
- Any fault records the first code only and enters FAULT. `o_position` keeps its last legal value.
- Lock counter: a 4-bit saturating counter, incremented on every Δ=±1 step accepted in SEED/UP/DOWN. `o_locked` = (count ≥ LOCK_COUNT) and state ∈ {UP, DOWN}. The counter clears on entry to IDLE or FAULT.
- `o_direction` is 1 in UP and 0 in DOWN. Its value in other states is the last tracking value, or 0 from reset.
- `i_clear` in any state: go to IDLE, clear the fault, code, lock counter and `o_valid`. Sweep count is preserved.
- Simultaneous `i_clear` and `i_sample`: the clear wins and the sample is discarded.

## Timing

- All outputs are registered. Outputs reflect a sample on the `i_clk` edge after the cycle with `i_sample`=1, giving 1-cycle latency.
- `o_sweep_pulse` is high for exactly the one cycle following the sample that reaches 0 or 15 in UP/DOWN.
- Reset (`i_n_rst`=0, asynchronous, at any time including mid-sweep or in FAULT) sets: state IDLE, `o_position`=0, `o_valid`=0, `o_direction`=0, `o_locked`=0, `o_fault`=0, `o_fault_code`=00, `o_sweep_count`=0, `o_sweep_pulse`=0. Release is synchronous to `i_clk`.
- `i_selection` is assumed stable in the cycle where `i_sample`=1. Synchronising an asynchronous bus is the integrator's job.

## Configuration

- `LARSON_MONITOR_SWEEP_COUNT_EN` defined: the sweep counter and pulse logic are present, as described above.
- Undefined: `o_sweep_count` is tied to 0 and `o_sweep_pulse` is tied to 0. The ports remain. The state machine, lock and fault behaviour are unchanged.

## Test plan

- Reset, then feed positions 0,1,…,15,14,…,0,1 with `i_sample` every cycle:
  - SEED at 0, UP at 1.
  - `o_locked`=1 after position 4.
  - Pulses at 15 and at 0; `o_sweep_count`=2.
  - `o_direction` follows 1→0→1.
  - `o_fault`=0 throughout.
- Tracking UP at 7, sample 16'hFFFF: `o_fault`=1, code 01, `o_position`=7, `o_locked`=0. Later legal samples are ignored.
- Tracking UP at 5, sample position 7: code 10. Then `i_clear`: IDLE, `o_valid`=0, `o_fault`=0, sweep count preserved.
- Tracking UP at 8, sample 7: code 11. Separately, two lines low (16'hFFFC): code 01.
- Assert `i_clear` and `i_sample` (position 3) in the same cycle while in UP: state is IDLE and `o_valid`=0, meaning the sample was discarded. The same position repeated in UP causes no change and no fault.
- Assert `i_n_rst` low asynchronously while in DOWN at 9 with count 3: all outputs go to reset values immediately, without a clock edge. With the macro undefined, the sweep outputs stay 0 throughout the first scenario.
